// File: rtl/scope_pkg.sv
// Shared definitions for the scope capture path: FSM state encoding and the
// default sample width.
package scope_pkg;

  localparam int DEFAULT_DATA_WIDTH = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } cap_state_e;

  function automatic logic state_busy(input cap_state_e s);
    return (s == ST_ARMED) || (s == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/trigger_capture_if.sv
// Display-side port of the capture block: frame handshake plus buffer read port.
interface trigger_capture_if #(
  parameter int DATA_WIDTH = scope_pkg::DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 640
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // frame_ready rises when a full capture sits in the buffer and stays high
  // until the display pulses frame_done for one cycle; frame_done seen while
  // no frame is held is dropped.
  logic                  frame_done;
  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  frame_ready;
  logic                  triggered;

  modport master (
    output frame_done,
    output rd_addr,
    input  rd_data,
    input  frame_ready,
    input  triggered
  );

  modport slave (
    input  frame_done,
    input  rd_addr,
    output rd_data,
    output frame_ready,
    output triggered
  );

endinterface

// File: rtl/trigger_capture_sample_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// Out-of-range read addresses return zero; the array itself has no reset.
module sample_ram #(
  parameter int DW    = 12,
  parameter int DEPTH = 640,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if ({1'b0, raddr} < DEPTH_V) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/trigger_capture.sv
// Oscilloscope trigger and capture: decimates the incoming sample stream,
// waits for a level crossing (or a timeout in auto mode) and fills one frame.
module trigger_capture
  import scope_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 640,
  parameter int DECIM      = 4,
  parameter int TIMEOUT    = 2048
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] trig_level,
  input  logic                  trig_slope,
  input  logic                  run,
  input  logic                  auto_mode,
  trigger_capture_if.slave      disp,
  output logic                  busy,
  output cap_state_e            fsm_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] DEC_LAST  = CW'(DECIM - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  cap_state_e            state;
  logic [CW-1:0]         dec_cnt;
  logic [TW-1:0]         to_cnt;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] prev_sample;
  logic                  frame_ready_q;
  logic                  triggered_q;

  logic                  strobe;
  logic                  rise_hit;
  logic                  fall_hit;
  logic                  trig_hit;
  logic                  timeout_hit;
  logic                  we;
  logic [AW-1:0]         waddr;

  assign strobe = (dec_cnt == DEC_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_cnt <= '0;
    end else if (strobe) begin
      dec_cnt <= '0;
    end else begin
      dec_cnt <= dec_cnt + 1'b1;
    end
  end

  // prev_sample follows the decimated stream in every state, so the first
  // strobe after arming already has a valid predecessor to compare against.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_sample <= '0;
    end else if (strobe) begin
      prev_sample <= data_in;
    end
  end

  always_comb begin
    rise_hit    = (prev_sample < trig_level) && (data_in >= trig_level);
    fall_hit    = (prev_sample > trig_level) && (data_in <= trig_level);
    trig_hit    = strobe && (trig_slope ? fall_hit : rise_hit);
    timeout_hit = strobe && auto_mode && (to_cnt == TO_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      to_cnt        <= '0;
      wr_addr       <= '0;
      frame_ready_q <= 1'b0;
      triggered_q   <= 1'b0;
    end else begin
      to_cnt <= '0;
      case (state)
        ST_IDLE: begin
          if (run) begin
            state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (!run) begin
            state <= ST_IDLE;
          end else if (trig_hit || timeout_hit) begin
            triggered_q <= trig_hit;
            if (DEPTH == 1) begin
              state         <= ST_HOLD;
              frame_ready_q <= 1'b1;
            end else begin
              state   <= ST_CAPTURE;
              wr_addr <= AW'(1);
            end
          end else if (strobe && (to_cnt != TO_LAST)) begin
            to_cnt <= to_cnt + 1'b1;
          end else begin
            // Saturate so auto mode switched on late forces on the next strobe.
            to_cnt <= to_cnt;
          end
        end
        ST_CAPTURE: begin
          if (strobe) begin
            if (wr_addr == LAST_ADDR) begin
              state         <= ST_HOLD;
              frame_ready_q <= 1'b1;
              wr_addr       <= '0;
            end else begin
              wr_addr <= wr_addr + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (disp.frame_done) begin
            frame_ready_q <= 1'b0;
            state         <= run ? ST_ARMED : ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // The triggering sample itself lands at address 0 on the arming strobe.
  always_comb begin
    we    = 1'b0;
    waddr = wr_addr;
    if (state == ST_ARMED) begin
      we    = run && (trig_hit || timeout_hit);
      waddr = '0;
    end else if (state == ST_CAPTURE) begin
      we = strobe;
    end
  end

  sample_ram #(
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (data_in),
    .raddr (disp.rd_addr),
    .rdata (disp.rd_data)
  );

  assign disp.frame_ready = frame_ready_q;
  assign disp.triggered   = triggered_q;
  assign busy             = state_busy(state);
  assign fsm_state        = state;

endmodule

// File: tb/tb_trigger_capture.sv
// Bench for trigger_capture: two instances (DECIM=1/DEPTH=8 and DECIM=4/DEPTH=6)
// driven by one sample stream, checked against a slot-level capture model.
module tb_trigger_capture;
  import scope_pkg::*;

  localparam int W       = 12;
  localparam int DEPTH_A = 8;
  localparam int DEPTH_B = 6;
  localparam int TO      = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [W-1:0] data_in;
  logic [W-1:0] trig_level;
  logic         trig_slope;
  logic         run;
  logic         auto_mode;
  logic         busy_a, busy_b;
  cap_state_e   st_a, st_b;

  trigger_capture_if #(.DATA_WIDTH(W), .DEPTH(DEPTH_A)) if_a ();
  trigger_capture_if #(.DATA_WIDTH(W), .DEPTH(DEPTH_B)) if_b ();

  trigger_capture #(.DATA_WIDTH(W), .DEPTH(DEPTH_A), .DECIM(1), .TIMEOUT(TO)) dut_a (
    .clk(clk), .reset(reset), .data_in(data_in), .trig_level(trig_level),
    .trig_slope(trig_slope), .run(run), .auto_mode(auto_mode),
    .disp(if_a.slave), .busy(busy_a), .fsm_state(st_a)
  );

  trigger_capture #(.DATA_WIDTH(W), .DEPTH(DEPTH_B), .DECIM(4), .TIMEOUT(TO)) dut_b (
    .clk(clk), .reset(reset), .data_in(data_in), .trig_level(trig_level),
    .trig_slope(trig_slope), .run(run), .auto_mode(auto_mode),
    .disp(if_b.slave), .busy(busy_b), .fsm_state(st_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] seq [64];
  logic [W-1:0] exp_mem [8];

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [$];
  bit           sel_q [$];
  bit           issue = 1'b0;
  bit           stage = 1'b0;
  bit           mon_sel;
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_act;

  always @(negedge clk) begin
    if (stage) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL rd_data: read returned with no expected value queued");
      end else begin
        mon_sel = sel_q.pop_front();
        mon_exp = exp_q.pop_front();
        mon_act = mon_sel ? if_b.rd_data : if_a.rd_data;
        if (mon_act == mon_exp) n_pass++;
        else $display("FAIL rd_data(dut_%s): got %0d expected %0d",
                      mon_sel ? "b" : "a", mon_act, mon_exp);
      end
    end
    stage = issue;
  end

  // ---------------- driver helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int get_fr(input bit sel);
    return sel ? int'(if_b.frame_ready) : int'(if_a.frame_ready);
  endfunction
  function automatic int get_trg(input bit sel);
    return sel ? int'(if_b.triggered) : int'(if_a.triggered);
  endfunction
  function automatic int get_busy(input bit sel);
    return sel ? int'(busy_b) : int'(busy_a);
  endfunction
  function automatic int get_st(input bit sel);
    return sel ? int'(st_b) : int'(st_a);
  endfunction

  task automatic do_reset();
    run = 1'b0;
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // One decimated sample period: junk on the non-strobe clocks, v on the strobe.
  task automatic slot(input int dec, input logic [W-1:0] v);
    for (int c = 0; c < dec; c++) begin
      data_in = (c == dec - 1) ? v : W'($urandom_range(0, 4095));
      cyc();
    end
  endtask

  // Reference model over strobe samples: returns the slot index of the first
  // captured sample (-1 none, -2 capture not finished within n slots).
  function automatic void model(input int n, input int k0, input int depth,
                                output int start, output bit trg);
    int lvl;
    lvl   = int'(trig_level);
    start = -1;
    trg   = 1'b0;
    for (int i = k0; i < n && start < 0; i++) begin
      int p;
      int s;
      bit t;
      p = (i == 0) ? 0 : int'(seq[i-1]);
      s = int'(seq[i]);
      t = trig_slope ? (p > lvl && s <= lvl) : (p < lvl && s >= lvl);
      if (t) begin
        start = i;
        trg   = 1'b1;
      end else if (auto_mode && (i - k0 == TO - 1)) begin
        start = i;
        trg   = 1'b0;
      end
    end
    if (start >= 0 && start + depth > n) start = -2;
  endfunction

  task automatic read_buf(input bit sel, input int depth);
    for (int a = 0; a < 8; a++) begin
      if (sel) if_b.rd_addr = 3'(a);
      else     if_a.rd_addr = 3'(a);
      exp_q.push_back((a < depth) ? exp_mem[a] : W'(0));
      sel_q.push_back(sel);
      issue = 1'b1;
      cyc();
    end
    issue = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic set_fd(input bit sel, input bit v);
    if (sel) if_b.frame_done = v;
    else     if_a.frame_done = v;
  endtask

  // Full capture scenario on one instance; seq[], level, slope and auto are
  // set up by the caller.
  task automatic run_capture(input string tag, input bit sel, input int n,
                             input int fd_at, input int run_off_at,
                             input int rst_at, input bit rearm);
    int dec;
    int depth;
    int k0;
    int start;
    bit trg;
    dec   = sel ? 4 : 1;
    depth = sel ? DEPTH_B : DEPTH_A;
    // With one clock per sample, the sample presented as run rises only seeds
    // prev_sample; with DECIM>1 arming happens before that slot's strobe.
    k0    = (dec == 1) ? 1 : 0;
    do_reset();
    model(n, k0, depth, start, trg);
    run = 1'b1;
    for (int i = 0; i < n; i++) begin
      set_fd(sel, i == fd_at);
      if (i == run_off_at) run = 1'b0;
      slot(dec, seq[i]);
      set_fd(sel, 1'b0);
      if (start >= 0 && i == start + depth - 2)
        check({tag, "_fr_early"}, get_fr(sel), 0);
      if (start >= 0 && i == start + depth - 1) begin
        check({tag, "_fr_done"}, get_fr(sel), 1);
        check({tag, "_triggered"}, get_trg(sel), int'(trg));
        check({tag, "_busy_hold"}, get_busy(sel), 0);
      end
      if (i == rst_at) begin
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check({tag, "_rst_state"}, get_st(sel), int'(ST_IDLE));
        check({tag, "_rst_fr"}, get_fr(sel), 0);
        check({tag, "_rst_busy"}, get_busy(sel), 0);
        run = 1'b0;
        return;
      end
    end
    if (start >= 0) begin
      check({tag, "_hold_state"}, get_st(sel), int'(ST_HOLD));
      for (int j = 0; j < depth; j++) exp_mem[j] = seq[start + j];
      read_buf(sel, depth);
      run = rearm;
      set_fd(sel, 1'b1);
      cyc();
      set_fd(sel, 1'b0);
      check({tag, "_fd_fr"}, get_fr(sel), 0);
      check({tag, "_fd_state"}, get_st(sel), rearm ? int'(ST_ARMED) : int'(ST_IDLE));
    end else begin
      check({tag, "_nofr"}, get_fr(sel), 0);
      check({tag, "_busy"}, get_busy(sel), 1);
      check({tag, "_wait_state"}, get_st(sel),
            (start == -1) ? int'(ST_ARMED) : int'(ST_CAPTURE));
      if (start == -1) begin
        run = 1'b0;
        cyc();
        check({tag, "_disarm"}, get_st(sel), int'(ST_IDLE));
      end
    end
    run = 1'b0;
    cyc();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    data_in        = '0;
    trig_level     = '0;
    trig_slope     = 1'b0;
    run            = 1'b0;
    auto_mode      = 1'b0;
    if_a.frame_done = 1'b0;
    if_b.frame_done = 1'b0;
    if_a.rd_addr   = '0;
    if_b.rd_addr   = '0;
    reset          = 1'b0;

    do_reset();
    check("rst_fr_a", get_fr(0), 0);
    check("rst_trg_a", get_trg(0), 0);
    check("rst_busy_a", get_busy(0), 0);
    check("rst_state_a", get_st(0), int'(ST_IDLE));
    check("rst_rd_a", int'(if_a.rd_data), 0);
    check("rst_fr_b", get_fr(1), 0);
    check("rst_busy_b", get_busy(1), 0);
    check("rst_rd_b", int'(if_b.rd_data), 0);

    // Rising ramp; frame_done and run drop during capture must not disturb it.
    trig_level = 12'd100; trig_slope = 1'b0; auto_mode = 1'b0;
    for (int i = 0; i < 64; i++) seq[i] = W'(90 + 5 * i);
    run_capture("ramp", 0, 16, 5, 6, -1, 0);

    // Falling edge 200 -> 50 across level 100.
    trig_slope = 1'b1;
    seq[0] = 12'd200; seq[1] = 12'd200; seq[2] = 12'd50;
    for (int i = 3; i < 64; i++) seq[i] = W'($urandom_range(0, 4095));
    run_capture("fall", 0, 16, 1, -1, -1, 0);

    // Flat signal: forced capture in auto mode, stays armed otherwise.
    trig_slope = 1'b0;
    for (int i = 0; i < 64; i++) seq[i] = 12'd10;
    auto_mode = 1'b1;
    run_capture("auto", 0, 30, -1, -1, -1, 0);
    auto_mode = 1'b0;
    run_capture("noauto", 0, 40, -1, -1, -1, 0);

    // Trigger on exactly the timeout strobe: trigger wins.
    auto_mode = 1'b1;
    seq[16] = 12'd150;
    run_capture("coincide", 0, 30, -1, -1, -1, 1);
    auto_mode = 1'b0;

    // Reset with write address at 3, then a fresh full capture.
    for (int i = 0; i < 64; i++) seq[i] = W'(90 + 5 * i);
    run_capture("midrst", 0, 16, -1, -1, 4, 0);
    for (int i = 0; i < 64; i++) seq[i] = W'(80 + 3 * i);
    run_capture("rerun", 0, 20, -1, -1, -1, 0);

    // Decimated instance: ramp, then auto-forced flat capture.
    for (int i = 0; i < 64; i++) seq[i] = W'(90 + 5 * i);
    run_capture("dec4_ramp", 1, 12, -1, -1, -1, 0);
    for (int i = 0; i < 64; i++) seq[i] = 12'd10;
    auto_mode = 1'b1;
    run_capture("dec4_auto", 1, 24, -1, -1, -1, 0);

    // Randomised scenarios around a random level.
    for (int t = 0; t < 10; t++) begin
      int lvl;
      lvl        = int'($urandom_range(100, 3900));
      trig_level = W'(lvl);
      trig_slope = 1'($urandom_range(0, 1));
      auto_mode  = 1'($urandom_range(0, 1));
      for (int i = 0; i < 64; i++) seq[i] = W'(lvl + int'($urandom_range(0, 80)) - 40);
      run_capture("rand", t[0], t[0] ? 30 : 40, -1, -1, -1, 1'($urandom_range(0, 1)));
    end

    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
